inst_fetch_queue: RTL and testbench

- Fetch stage directly downstream of the PC generator.
- Consumes pc/ce and issues in-order instruction-memory reads.
- Buffers returned instructions with their PC in a small in-order queue and hands them to decode over a valid/ready handshake.
- Back-pressures the PC generator through stall; supports flush on branch redirect.

---
 rtl/inst_fetch_queue_pkg.sv | 21 ++
 rtl/inst_fetch_queue_mem.sv | 47 ++++
 rtl/inst_fetch_queue.sv | 146 ++++++++++++++
 tb/tb_inst_fetch_queue.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue.
// Holds the address/instruction width macros and the default queue depth.
`ifndef INST_FETCH_QUEUE_DEFINES
`define INST_FETCH_QUEUE_DEFINES
`define Inst_Addr_Width 32
`define Inst_Width 32
`define Inst_Fetch_Depth 4
`endif

package inst_fetch_queue_pkg;

   localparam int unsigned DefAddrW = `Inst_Addr_Width;
   localparam int unsigned DefInstW = `Inst_Width;
   localparam int unsigned DefDepth = `Inst_Fetch_Depth;

   // Queue pointers carry one extra MSB so full and empty are distinguishable.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/inst_fetch_queue_mem.sv
// Fetch queue storage: DEPTH entries of {pc, inst}.
// The pc half is written on allocate, the inst half on memory fill; reads are asynchronous.
module inst_fetch_queue_mem
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned INST_W = DefInstW,
   parameter int unsigned DEPTH  = DefDepth
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alloc_we,
   input  logic [$clog2(DEPTH)-1:0] alloc_idx,
   input  logic [ADDR_W-1:0]        alloc_pc,
   input  logic                     fill_we,
   input  logic [$clog2(DEPTH)-1:0] fill_idx,
   input  logic [INST_W-1:0]        fill_inst,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic [ADDR_W-1:0]        rd_pc,
   output logic [INST_W-1:0]        rd_inst
);

   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [INST_W-1:0] inst_q [DEPTH];

   // PC half: captured when the entry is allocated.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) pc_q[i] <= '0;
      end else if (alloc_we) begin
         pc_q[alloc_idx] <= alloc_pc;
      end
   end

   // Instruction half: captured when the matching read returns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) inst_q[i] <= '0;
      end else if (fill_we) begin
         inst_q[fill_idx] <= fill_inst;
      end
   end

   assign rd_pc   = pc_q[rd_idx];
   assign rd_inst = inst_q[rd_idx];

endmodule

// File: rtl/inst_fetch_queue.sv
// In-order instruction fetch queue between the PC generator and decode.
// Optional macro FETCH_BYPASS_EN: a response for an unfilled head entry is
// forwarded to decode in the same cycle it arrives.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned INST_W = DefInstW,
   parameter int unsigned DEPTH  = DefDepth
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   input  logic              pc_ce,
   output logic              stall,
   output logic              mem_ce,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [INST_W-1:0] mem_rdata,
   input  logic              flush,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [INST_W-1:0] dec_inst,
   output logic [ADDR_W-1:0] dec_pc
);

   localparam int unsigned PtrW  = ptr_width(DEPTH);
   localparam int unsigned IdxW  = PtrW - 1;
   // Headroom for discards accumulated across back-to-back flushes.
   localparam int unsigned DropW = PtrW + 2;

   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   fill_ptr_q, fill_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0]  filled_q, filled_d;
   logic [DropW-1:0]  drop_cnt_q, drop_cnt_d;
   logic              mem_ce_q, mem_ce_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

   logic [PtrW-1:0]   count, credits, in_flight;
   logic [IdxW-1:0]   wr_idx, fill_idx, rd_idx;
   logic              alloc, fill_rsp, bypass, pop;
   logic [INST_W-1:0] head_inst;

   assign count     = wr_ptr_q - rd_ptr_q;
   assign credits   = PtrW'(DEPTH) - count;
   assign in_flight = wr_ptr_q - fill_ptr_q;
   assign wr_idx    = wr_ptr_q[IdxW-1:0];
   assign fill_idx  = fill_ptr_q[IdxW-1:0];
   assign rd_idx    = rd_ptr_q[IdxW-1:0];

   // One slot of slack covers the request issued in the cycle stall rises.
   assign stall    = (credits <= PtrW'(1)) && !flush;
   assign alloc    = pc_ce && (credits != '0) && !flush;
   assign fill_rsp = mem_rvalid && (drop_cnt_q == '0) && !flush;

`ifdef FETCH_BYPASS_EN
   assign bypass = fill_rsp && (fill_ptr_q == rd_ptr_q) && (count != '0);
`else
   assign bypass = 1'b0;
`endif

   assign dec_valid = !flush && (count != '0) && (filled_q[rd_idx] || bypass);
   assign dec_inst  = bypass ? mem_rdata : head_inst;
   assign pop       = dec_valid && dec_ready;
   assign mem_ce    = mem_ce_q;
   assign mem_addr  = mem_addr_q;

   inst_fetch_queue_mem #(
      .ADDR_W(ADDR_W),
      .INST_W(INST_W),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk      (clk),
      .rst      (rst),
      .alloc_we (alloc),
      .alloc_idx(wr_idx),
      .alloc_pc (pc),
      .fill_we  (fill_rsp),
      .fill_idx (fill_idx),
      .fill_inst(mem_rdata),
      .rd_idx   (rd_idx),
      .rd_pc    (dec_pc),
      .rd_inst  (head_inst)
   );

   // Next-state for pointers, filled flags, discard counter and read request.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      fill_ptr_d = fill_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      filled_d   = filled_q;
      drop_cnt_d = drop_cnt_q;
      mem_ce_d   = alloc;
      mem_addr_d = alloc ? pc : mem_addr_q;
      if (flush) begin
         // Every read not yet returned must be swallowed; a response arriving
         // now is consumed whether it was due to fill or to be dropped.
         wr_ptr_d   = '0;
         fill_ptr_d = '0;
         rd_ptr_d   = '0;
         filled_d   = '0;
         drop_cnt_d = drop_cnt_q + DropW'(in_flight) - DropW'(mem_rvalid);
      end else begin
         if (mem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - DropW'(1);
         if (pop) begin
            rd_ptr_d         = rd_ptr_q + PtrW'(1);
            filled_d[rd_idx] = 1'b0;
         end
         if (fill_rsp) begin
            fill_ptr_d = fill_ptr_q + PtrW'(1);
            if (!(bypass && dec_ready)) filled_d[fill_idx] = 1'b1;
         end
         if (alloc) begin
            wr_ptr_d         = wr_ptr_q + PtrW'(1);
            filled_d[wr_idx] = 1'b0;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         fill_ptr_q <= '0;
         rd_ptr_q   <= '0;
         filled_q   <= '0;
         drop_cnt_q <= '0;
         mem_ce_q   <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         fill_ptr_q <= fill_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         filled_q   <= filled_d;
         drop_cnt_q <= drop_cnt_d;
         mem_ce_q   <= mem_ce_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   // A request with no credit left means the PC generator ignored stall.
   a_no_overrun: assert property (@(posedge clk) disable iff (rst)
      !(pc_ce && !flush && (credits == '0)));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue (scoreboard of expected PCs).
module tb_inst_fetch_queue;

   localparam int unsigned AW    = 32;
   localparam int unsigned IW    = 32;
   localparam int unsigned DEPTH = 4;
`ifdef FETCH_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] pc;
   logic          pc_ce;
   logic          stall;
   logic          mem_ce;
   logic [AW-1:0] mem_addr;
   logic          mem_rvalid;
   logic [IW-1:0] mem_rdata;
   logic          flush;
   logic          dec_valid;
   logic          dec_ready;
   logic [IW-1:0] dec_inst;
   logic [AW-1:0] dec_pc;

   always #5 clk = ~clk;

   inst_fetch_queue #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .pc(pc), .pc_ce(pc_ce), .stall(stall), .mem_ce(mem_ce),
      .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [IW-1:0] data;
      int            due;
   } mem_req_t;

   mem_req_t      mem_q[$];
   logic [AW-1:0] exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;

   bit            gen_en, gen_lag, mem_rand, flush_req, stall_prev;
   int            gen_left, mem_lat, ready_mode;
   logic [AW-1:0] next_pc;

   bit            obs_pop, obs_valid, obs_stall, obs_rvalid, obs_alloc, obs_mem_ce;
   logic [AW-1:0] obs_pc;
   logic [IW-1:0] obs_inst;
   int            obs_cnt;

   function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] a);
      return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
   endfunction

   // One clock of PC generator, memory model and decode sink; samples outputs.
   task automatic cycle();
      @(negedge clk);
      cyc++;
      obs_cnt    = exp_q.size();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc && (!mem_rand || $urandom_range(0, 2) != 0))
      begin
         mem_rvalid = 1'b1;
         mem_rdata  = mem_q[0].data;
         void'(mem_q.pop_front());
      end
      if (mem_ce) mem_q.push_back('{addr: mem_addr, data: inst_of(mem_addr), due: cyc + mem_lat});
      obs_mem_ce = mem_ce;
      flush      = flush_req;
      dec_ready  = (ready_mode == 2) ? ($urandom_range(0, 1) == 1) : (ready_mode == 1);
      pc_ce      = 1'b0;
      #1;
      pc = next_pc;
      if (gen_en && gen_left > 0 && !flush && !(gen_lag ? stall_prev : stall)) begin
         pc_ce = 1'b1;
         exp_q.push_back(next_pc);
         next_pc  += 4;
         gen_left--;
      end
      #1;
      obs_valid  = dec_valid;
      obs_stall  = stall;
      obs_pc     = dec_pc;
      obs_inst   = dec_inst;
      obs_rvalid = mem_rvalid;
      obs_alloc  = pc_ce;
      obs_pop    = dec_valid && dec_ready;
      stall_prev = stall;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (mem_ce !== 1'b0) begin errors++; $display("FAIL reset_mem_ce: got %b want 0", mem_ce); end
      checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
      checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid); end
      checks++; if (dec_inst !== '0) begin errors++; $display("FAIL reset_dec_inst: got %h want 0", dec_inst); end
      checks++; if (dec_pc !== '0) begin errors++; $display("FAIL reset_dec_pc: got %h want 0", dec_pc); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_steady_stream();
      int n = 0, first_alloc = -1, first_pop = -1;
      logic [AW-1:0] e;
      gen_en = 1; gen_lag = 0; ready_mode = 1; mem_lat = 1; mem_rand = 0;
      gen_left = 12; next_pc = 32'h0;
      for (int i = 0; i < 200 && (gen_left > 0 || exp_q.size() > 0); i++) begin
         cycle();
         if (obs_alloc && first_alloc < 0) first_alloc = cyc;
         if (obs_pop) begin
            if (first_pop < 0) first_pop = cyc;
            n++; checks++;
            e = exp_q.size() ? exp_q.pop_front() : 32'hffff_ffff;
            if (obs_pc !== e || obs_inst !== inst_of(e)) begin
               errors++; $display("FAIL steady_order: got pc %h inst %h want pc %h inst %h", obs_pc, obs_inst, e, inst_of(e));
            end
         end
      end
      checks++; if (n != 12) begin errors++; $display("FAIL steady_count: got %0d want 12", n); end
      checks++;
      if (first_pop - first_alloc != (Bypass ? 2 : 3)) begin
         errors++; $display("FAIL steady_latency: got %0d want %0d", first_pop - first_alloc, Bypass ? 2 : 3);
      end
   endtask

   task automatic test_back_pressure();
      logic [AW-1:0] e;
      gen_en = 1; gen_lag = 1; ready_mode = 0; mem_lat = 1; mem_rand = 0;
      gen_left = 8; next_pc = 32'h1000; stall_prev = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         checks++;
         if (obs_stall !== (obs_cnt >= DEPTH - 1)) begin
            errors++; $display("FAIL bp_stall: got %b want %b (occupancy %0d)", obs_stall, obs_cnt >= DEPTH - 1, obs_cnt);
         end
      end
      checks++; if (exp_q.size() != DEPTH) begin errors++; $display("FAIL bp_alloc_count: got %0d want %0d", exp_q.size(), DEPTH); end
      ready_mode = 1;
      for (int i = 0; i < 100 && (gen_left > 0 || exp_q.size() > 0); i++) begin
         cycle();
         checks++;
         if (obs_stall !== (obs_cnt >= DEPTH - 1)) begin
            errors++; $display("FAIL bp_drain_stall: got %b want %b", obs_stall, obs_cnt >= DEPTH - 1);
         end
         if (obs_pop) begin
            checks++;
            e = exp_q.size() ? exp_q.pop_front() : 32'hffff_ffff;
            if (obs_pc !== e || obs_inst !== inst_of(e)) begin
               errors++; $display("FAIL bp_order: got pc %h inst %h want pc %h", obs_pc, obs_inst, e);
            end
         end
      end
      checks++; if (exp_q.size() != 0 || gen_left != 0) begin errors++; $display("FAIL bp_drain_timeout: left %0d", exp_q.size()); end
   endtask

   task automatic test_flush();
      int n = 0;
      logic [AW-1:0] e;
      gen_en = 1; gen_lag = 0; ready_mode = 0; mem_lat = 1; mem_rand = 0;
      gen_left = 3; next_pc = 32'h2000;
      cycle();                  // alloc A
      cycle();                  // alloc B, read A issued
      mem_lat = 6;
      cycle();                  // alloc C, A returns, read B issued (slow)
      cycle();                  // read C issued (slow); A now at head
      checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b want 1", obs_valid); end
      flush_req = 1;
      cycle();
      flush_req = 0;
      checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle_valid: got %b want 0", obs_valid); end
      checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL flush_cycle_stall: got %b want 0", obs_stall); end
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].data = 32'hdead_0001 + i;
      mem_lat = 1; ready_mode = 1; gen_left = 1; next_pc = 32'h100;
      for (int i = 0; i < 40 && exp_q.size() + gen_left > 0; i++) begin
         cycle();
         if (obs_pop) begin
            n++; checks++;
            e = exp_q.size() ? exp_q.pop_front() : 32'hffff_ffff;
            if (obs_pc !== e || obs_inst !== inst_of(e)) begin
               errors++; $display("FAIL flush_refetch: got pc %h inst %h want pc %h inst %h", obs_pc, obs_inst, e, inst_of(e));
            end
         end
      end
      checks++; if (n != 1) begin errors++; $display("FAIL flush_refetch_count: got %0d want 1", n); end
   endtask

   task automatic test_async_reset();
      gen_en = 1; gen_lag = 0; ready_mode = 0; mem_lat = 1; mem_rand = 0;
      gen_left = 3; next_pc = 32'h3000;
      cycle(); cycle(); cycle();
      @(posedge clk);
      #2;
      checks++;
      if ({mem_ce, dec_valid, stall} !== 3'b111) begin
         errors++; $display("FAIL arst_pre: got %b want 111", {mem_ce, dec_valid, stall});
      end
      rst = 1'b1;
      #1;
      checks++; if (mem_ce !== 1'b0) begin errors++; $display("FAIL arst_mem_ce: got %b want 0", mem_ce); end
      checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL arst_dec_valid: got %b want 0", dec_valid); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL arst_stall: got %b want 0", stall); end
      @(negedge clk);
      pc_ce = 0; mem_rvalid = 0; flush = 0;
      mem_q.delete(); exp_q.delete(); stall_prev = 0; gen_en = 0; gen_left = 0;
      @(negedge clk);
      rst = 1'b0;
      ready_mode = 1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (obs_valid !== 1'b0 || obs_mem_ce !== 1'b0) begin
            errors++; $display("FAIL arst_post: got valid %b mem_ce %b want 0 0", obs_valid, obs_mem_ce);
         end
      end
   endtask

   task automatic test_wrap();
      int n = 0;
      logic [AW-1:0] e;
      gen_en = 1; gen_lag = 1; ready_mode = 2; mem_lat = 1; mem_rand = 1;
      gen_left = 3 * DEPTH + 1; next_pc = 32'h4000;
      for (int i = 0; i < 600 && (gen_left > 0 || exp_q.size() > 0); i++) begin
         cycle();
         if (obs_pop) begin
            n++; checks++;
            e = exp_q.size() ? exp_q.pop_front() : 32'hffff_ffff;
            if (obs_pc !== e || obs_inst !== inst_of(e)) begin
               errors++; $display("FAIL wrap_order: got pc %h inst %h want pc %h", obs_pc, obs_inst, e);
            end
         end
      end
      checks++; if (n != 3 * DEPTH + 1) begin errors++; $display("FAIL wrap_count: got %0d want %0d", n, 3 * DEPTH + 1); end
      mem_rand = 0;
   endtask

   task automatic test_latency();
      int rsp = -1;
      logic [AW-1:0] e;
      gen_en = 1; gen_lag = 0; ready_mode = 1; mem_lat = 1; mem_rand = 0;
      gen_left = 1; next_pc = 32'h5000;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (obs_rvalid && rsp < 0) begin
            rsp = cyc; checks++;
            if (obs_valid !== Bypass) begin errors++; $display("FAIL lat_same_cycle: got %b want %b", obs_valid, Bypass); end
            if (Bypass && obs_valid && obs_inst !== mem_rdata) begin
               errors++; $display("FAIL lat_bypass_inst: got %h want %h", obs_inst, mem_rdata);
            end
         end else if (rsp >= 0 && cyc == rsp + 1) begin
            checks++;
            if (obs_valid !== !Bypass) begin errors++; $display("FAIL lat_next_cycle: got %b want %b", obs_valid, !Bypass); end
         end
         if (obs_pop) begin
            checks++;
            e = exp_q.size() ? exp_q.pop_front() : 32'hffff_ffff;
            if (obs_pc !== e || obs_inst !== inst_of(e)) begin
               errors++; $display("FAIL lat_data: got pc %h inst %h want pc %h", obs_pc, obs_inst, e);
            end
         end
      end
      checks++; if (rsp < 0) begin errors++; $display("FAIL lat_timeout: got no response want one"); end
   endtask

   initial begin
      rst = 1'b1; pc = '0; pc_ce = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      flush = 1'b0; dec_ready = 1'b0;
      gen_en = 0; gen_lag = 0; mem_rand = 0; flush_req = 0; stall_prev = 0;
      gen_left = 0; mem_lat = 1; ready_mode = 0; next_pc = '0;
      test_reset();
      test_steady_stream();
      test_back_pressure();
      test_flush();
      test_async_reset();
      test_wrap();
      test_latency();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
